// File: rtl/id_ex_stage_if.sv
// ID->EX pipeline bundle: decoded control, operands and register indices on
// the ID side, and their registered copies on the EX side.
interface id_ex_stage_if #(
    parameter int XLEN = 32
);
    logic            id_RegWrite, id_MemWrite, id_Memread;
    logic [5:0]      id_EXTOp;
    logic [4:0]      id_ALUOp;
    logic [2:0]      id_NPCOp;
    logic            id_ALUSrc;
    logic [2:0]      id_WDSel, id_dm_ctrl;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic            id_uses_rs1, id_uses_rs2, id_valid;

    logic            ex_RegWrite, ex_MemWrite, ex_Memread;
    logic [5:0]      ex_EXTOp;
    logic [4:0]      ex_ALUOp;
    logic [2:0]      ex_NPCOp;
    logic            ex_ALUSrc;
    logic [2:0]      ex_WDSel, ex_dm_ctrl;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic            ex_valid;

    modport master (
        output id_RegWrite, id_MemWrite, id_Memread, id_EXTOp, id_ALUOp, id_NPCOp,
               id_ALUSrc, id_WDSel, id_dm_ctrl, id_pc, id_rs1_data, id_rs2_data,
               id_imm, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2, id_valid,
        input  ex_RegWrite, ex_MemWrite, ex_Memread, ex_EXTOp, ex_ALUOp, ex_NPCOp,
               ex_ALUSrc, ex_WDSel, ex_dm_ctrl, ex_pc, ex_rs1_data, ex_rs2_data,
               ex_imm, ex_rs1, ex_rs2, ex_rd, ex_valid
    );

    modport slave (
        input  id_RegWrite, id_MemWrite, id_Memread, id_EXTOp, id_ALUOp, id_NPCOp,
               id_ALUSrc, id_WDSel, id_dm_ctrl, id_pc, id_rs1_data, id_rs2_data,
               id_imm, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2, id_valid,
        output ex_RegWrite, ex_MemWrite, ex_Memread, ex_EXTOp, ex_ALUOp, ex_NPCOp,
               ex_ALUSrc, ex_WDSel, ex_dm_ctrl, ex_pc, ex_rs1_data, ex_rs2_data,
               ex_imm, ex_rs1, ex_rs2, ex_rd, ex_valid
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush handling,
// downstream hold and a saturating bubble counter.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    id_ex_stage_if.slave     bus,
    input  logic             flush,
    input  logic             hold,
    output logic             stall,
    output logic [CNT_W-1:0] bubble_cnt
);
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic [5:0] ext_op;
        logic [4:0] alu_op;
        logic [2:0] npc_op;
        logic       alu_src;
        logic [2:0] wd_sel;
        logic [2:0] dm_ctrl;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } data_t;

    ctrl_t            ctrl_q, ctrl_d, id_ctrl;
    data_t            data_q, data_d, id_data;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hazard;

    assign id_ctrl = '{reg_write: bus.id_RegWrite, mem_write: bus.id_MemWrite,
                       mem_read: bus.id_Memread, ext_op: bus.id_EXTOp,
                       alu_op: bus.id_ALUOp, npc_op: bus.id_NPCOp,
                       alu_src: bus.id_ALUSrc, wd_sel: bus.id_WDSel,
                       dm_ctrl: bus.id_dm_ctrl};
    assign id_data = '{pc: bus.id_pc, rs1_data: bus.id_rs1_data,
                       rs2_data: bus.id_rs2_data, imm: bus.id_imm,
                       rs1: bus.id_rs1, rs2: bus.id_rs2, rd: bus.id_rd};

    // A load in EX whose nonzero destination the ID instruction reads.
    assign hazard = valid_q & ctrl_q.mem_read & (data_q.rd != 5'd0) & bus.id_valid &
                    ((bus.id_uses_rs1 & (bus.id_rs1 == data_q.rd)) |
                     (bus.id_uses_rs2 & (bus.id_rs2 == data_q.rd)));

    // Flush overrides the hazard stall: IF/ID is being replaced anyway.
    assign stall = rstn & (hold | (hazard & ~flush));

    always_comb begin
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (hold) begin
            // frozen; a pending flush is re-asserted by the frozen redirector
        end else if (flush) begin
            ctrl_d  = '0;
            data_d  = '0;
            valid_d = 1'b0;
        end else if (hazard) begin
            ctrl_d  = '0;
            data_d  = '0;
            valid_d = 1'b0;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        end else begin
            ctrl_d  = bus.id_valid ? id_ctrl : '0;
            data_d  = id_data;
            valid_d = bus.id_valid;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctrl_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ex_RegWrite = ctrl_q.reg_write;
    assign bus.ex_MemWrite = ctrl_q.mem_write;
    assign bus.ex_Memread  = ctrl_q.mem_read;
    assign bus.ex_EXTOp    = ctrl_q.ext_op;
    assign bus.ex_ALUOp    = ctrl_q.alu_op;
    assign bus.ex_NPCOp    = ctrl_q.npc_op;
    assign bus.ex_ALUSrc   = ctrl_q.alu_src;
    assign bus.ex_WDSel    = ctrl_q.wd_sel;
    assign bus.ex_dm_ctrl  = ctrl_q.dm_ctrl;
    assign bus.ex_pc       = data_q.pc;
    assign bus.ex_rs1_data = data_q.rs1_data;
    assign bus.ex_rs2_data = data_q.rs2_data;
    assign bus.ex_imm      = data_q.imm;
    assign bus.ex_rs1      = data_q.rs1;
    assign bus.ex_rs2      = data_q.rs2;
    assign bus.ex_rd       = data_q.rd;
    assign bus.ex_valid    = valid_q;
    assign bubble_cnt      = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus a randomized run against an
// instruction-level model; a CNT_W=2 twin shares stimulus to exercise saturation.
module tb_id_ex_stage;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        hold = 1'b0;
    logic        stall, stall2;
    logic [15:0] bubble_cnt;
    logic [1:0]  bubble_cnt2;
    int          n_pass = 0;
    int          n_tot = 0;
    int          exp_bub = 0;

    id_ex_stage_if #(.XLEN(XLEN)) bus ();
    id_ex_stage_if #(.XLEN(XLEN)) bus2 ();

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .bus(bus), .flush(flush), .hold(hold),
        .stall(stall), .bubble_cnt(bubble_cnt));

    id_ex_stage #(.XLEN(XLEN), .CNT_W(2)) dut_sat (
        .clk(clk), .rstn(rstn), .bus(bus2), .flush(flush), .hold(hold),
        .stall(stall2), .bubble_cnt(bubble_cnt2));

    assign bus2.id_RegWrite = bus.id_RegWrite;
    assign bus2.id_MemWrite = bus.id_MemWrite;
    assign bus2.id_Memread  = bus.id_Memread;
    assign bus2.id_EXTOp    = bus.id_EXTOp;
    assign bus2.id_ALUOp    = bus.id_ALUOp;
    assign bus2.id_NPCOp    = bus.id_NPCOp;
    assign bus2.id_ALUSrc   = bus.id_ALUSrc;
    assign bus2.id_WDSel    = bus.id_WDSel;
    assign bus2.id_dm_ctrl  = bus.id_dm_ctrl;
    assign bus2.id_pc       = bus.id_pc;
    assign bus2.id_rs1_data = bus.id_rs1_data;
    assign bus2.id_rs2_data = bus.id_rs2_data;
    assign bus2.id_imm      = bus.id_imm;
    assign bus2.id_rs1      = bus.id_rs1;
    assign bus2.id_rs2      = bus.id_rs2;
    assign bus2.id_rd       = bus.id_rd;
    assign bus2.id_uses_rs1 = bus.id_uses_rs1;
    assign bus2.id_uses_rs2 = bus.id_uses_rs2;
    assign bus2.id_valid    = bus.id_valid;

    // One instruction as it sits in a pipeline slot.
    typedef struct packed {
        logic            RegWrite, MemWrite, Memread;
        logic [5:0]      EXTOp;
        logic [4:0]      ALUOp;
        logic [2:0]      NPCOp;
        logic            ALUSrc;
        logic [2:0]      WDSel, dm_ctrl;
        logic [XLEN-1:0] pc, rs1_data, rs2_data, imm;
        logic [4:0]      rs1, rs2, rd;
        logic            valid;
    } rec_t;

    rec_t m;
    int   m_cnt, m_cnt2;

    function automatic rec_t obs();
        rec_t r;
        r = '{bus.ex_RegWrite, bus.ex_MemWrite, bus.ex_Memread, bus.ex_EXTOp,
              bus.ex_ALUOp, bus.ex_NPCOp, bus.ex_ALUSrc, bus.ex_WDSel, bus.ex_dm_ctrl,
              bus.ex_pc, bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm,
              bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_valid};
        return r;
    endfunction

    function automatic rec_t id_rec();
        rec_t r;
        r = '{bus.id_RegWrite, bus.id_MemWrite, bus.id_Memread, bus.id_EXTOp,
              bus.id_ALUOp, bus.id_NPCOp, bus.id_ALUSrc, bus.id_WDSel, bus.id_dm_ctrl,
              bus.id_pc, bus.id_rs1_data, bus.id_rs2_data, bus.id_imm,
              bus.id_rs1, bus.id_rs2, bus.id_rd, bus.id_valid};
        return r;
    endfunction

    function automatic rec_t rand_rec();
        rec_t r;
        r.RegWrite = 1'($urandom); r.MemWrite = 1'($urandom); r.Memread = 1'($urandom);
        r.EXTOp = 6'($urandom); r.ALUOp = 5'($urandom); r.NPCOp = 3'($urandom);
        r.ALUSrc = 1'($urandom); r.WDSel = 3'($urandom); r.dm_ctrl = 3'($urandom);
        r.pc = $urandom; r.rs1_data = $urandom; r.rs2_data = $urandom; r.imm = $urandom;
        r.rs1 = 5'($urandom); r.rs2 = 5'($urandom); r.rd = 5'($urandom);
        r.valid = 1'b1;
        return r;
    endfunction

    function automatic rec_t mk(input logic rw, input logic mr, input logic [4:0] alu,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] pc);
        rec_t r;
        r = '0;
        r.RegWrite = rw; r.Memread = mr; r.ALUOp = alu; r.EXTOp = 6'b000010;
        r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.pc = pc;
        r.rs1_data = $urandom; r.rs2_data = $urandom; r.imm = $urandom;
        r.valid = 1'b1;
        return r;
    endfunction

    task automatic set_id(input rec_t r, input logic u1, input logic u2);
        bus.id_RegWrite = r.RegWrite; bus.id_MemWrite = r.MemWrite;
        bus.id_Memread = r.Memread; bus.id_EXTOp = r.EXTOp; bus.id_ALUOp = r.ALUOp;
        bus.id_NPCOp = r.NPCOp; bus.id_ALUSrc = r.ALUSrc; bus.id_WDSel = r.WDSel;
        bus.id_dm_ctrl = r.dm_ctrl; bus.id_pc = r.pc; bus.id_rs1_data = r.rs1_data;
        bus.id_rs2_data = r.rs2_data; bus.id_imm = r.imm; bus.id_rs1 = r.rs1;
        bus.id_rs2 = r.rs2; bus.id_rd = r.rd; bus.id_valid = r.valid;
        bus.id_uses_rs1 = u1; bus.id_uses_rs2 = u2;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Model: a load in EX blocks an ID instruction that reads its real destination.
    function automatic logic m_load_use();
        logic reads_it;
        reads_it = (bus.id_uses_rs1 && bus.id_rs1 == m.rd) ||
                   (bus.id_uses_rs2 && bus.id_rs2 == m.rd);
        return m.valid && m.Memread && m.rd != 0 && bus.id_valid && reads_it;
    endfunction

    task automatic model_edge();
        rec_t nxt;
        if (hold) return;
        if (flush) begin
            m = '0;
        end else if (m_load_use()) begin
            m = '0;
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end else begin
            nxt = id_rec();
            if (!nxt.valid) begin
                nxt.RegWrite = 0; nxt.MemWrite = 0; nxt.Memread = 0; nxt.EXTOp = 0;
                nxt.ALUOp = 0; nxt.NPCOp = 0; nxt.ALUSrc = 0; nxt.WDSel = 0; nxt.dm_ctrl = 0;
            end
            m = nxt;
        end
    endtask

    task automatic test_reset();
        rec_t add;
        rstn = 1'b0; hold = 1'b1; flush = 1'b0;
        set_id(rand_rec(), 1'b1, 1'b1);
        tick(); tick();
        n_tot++; if (obs() !== '0) $display("FAIL reset_ex got %h want 0", obs()); else n_pass++;
        n_tot++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else n_pass++;
        n_tot++; if (bubble_cnt !== 16'd0) $display("FAIL reset_cnt got %0d want 0", bubble_cnt); else n_pass++;
        hold = 1'b0;
        add = mk(1'b1, 1'b0, 5'b00011, 5'd5, 5'd1, 5'd2, 32'h10);
        set_id(add, 1'b1, 1'b1);
        rstn = 1'b1;
        tick();
        n_tot++; if (obs() !== add) $display("FAIL first_capture got %h want %h", obs(), add); else n_pass++;
        n_tot++; if (stall !== 1'b0) $display("FAIL first_stall got %b want 0", stall); else n_pass++;
        exp_bub = 0;
    endtask

    task automatic test_load_use();
        rec_t lw, add;
        lw  = mk(1'b1, 1'b1, 5'b00001, 5'd6, 5'd1, 5'd0, 32'h14);
        add = mk(1'b1, 1'b0, 5'b00011, 5'd8, 5'd6, 5'd3, 32'h18);
        set_id(lw, 1'b1, 1'b0); tick();
        set_id(add, 1'b1, 1'b1); #1;
        n_tot++; if (stall !== 1'b1) $display("FAIL lu_stall got %b want 1", stall); else n_pass++;
        tick(); exp_bub++;
        n_tot++; if (obs() !== '0) $display("FAIL lu_bubble got %h want 0", obs()); else n_pass++;
        n_tot++; if (bubble_cnt !== 16'(exp_bub)) $display("FAIL lu_cnt got %0d want %0d", bubble_cnt, exp_bub); else n_pass++;
        n_tot++; if (stall !== 1'b0) $display("FAIL lu_release got %b want 0", stall); else n_pass++;
        tick();
        n_tot++; if (obs() !== add) $display("FAIL lu_advance got %h want %h", obs(), add); else n_pass++;
    endtask

    task automatic test_no_false_hazard();
        rec_t ld, use0;
        ld   = mk(1'b1, 1'b1, 5'b00001, 5'd0, 5'd2, 5'd0, 32'h20);
        use0 = mk(1'b1, 1'b0, 5'b00011, 5'd4, 5'd0, 5'd0, 32'h24);
        set_id(ld, 1'b1, 1'b0); tick();
        set_id(use0, 1'b1, 1'b1); #1;
        n_tot++; if (stall !== 1'b0) $display("FAIL x0_stall got %b want 0", stall); else n_pass++;
        tick();
        n_tot++; if (obs() !== use0) $display("FAIL x0_advance got %h want %h", obs(), use0); else n_pass++;
        ld   = mk(1'b1, 1'b1, 5'b00001, 5'd7, 5'd2, 5'd0, 32'h28);
        use0 = mk(1'b1, 1'b0, 5'b00011, 5'd4, 5'd3, 5'd7, 32'h2c);
        set_id(ld, 1'b1, 1'b0); tick();
        set_id(use0, 1'b1, 1'b0); #1;
        n_tot++; if (stall !== 1'b0) $display("FAIL unused_rs2_stall got %b want 0", stall); else n_pass++;
        tick();
        n_tot++; if (obs() !== use0) $display("FAIL unused_rs2_adv got %h want %h", obs(), use0); else n_pass++;
        n_tot++; if (bubble_cnt !== 16'(exp_bub)) $display("FAIL nofalse_cnt got %0d want %0d", bubble_cnt, exp_bub); else n_pass++;
    endtask

    task automatic test_flush_hazard();
        rec_t ld, cons;
        ld   = mk(1'b1, 1'b1, 5'b00001, 5'd9, 5'd2, 5'd0, 32'h30);
        cons = mk(1'b0, 1'b0, 5'b00000, 5'd0, 5'd1, 5'd9, 32'h34);
        set_id(ld, 1'b1, 1'b0); tick();
        set_id(cons, 1'b1, 1'b1); flush = 1'b1; #1;
        n_tot++; if (stall !== 1'b0) $display("FAIL flush_stall got %b want 0", stall); else n_pass++;
        tick(); flush = 1'b0;
        n_tot++; if (obs() !== '0) $display("FAIL flush_bubble got %h want 0", obs()); else n_pass++;
        n_tot++; if (bubble_cnt !== 16'(exp_bub)) $display("FAIL flush_cnt got %0d want %0d", bubble_cnt, exp_bub); else n_pass++;
    endtask

    task automatic test_hold();
        rec_t x, y, snap;
        x = mk(1'b1, 1'b0, 5'b00100, 5'd12, 5'd1, 5'd2, 32'h40);
        set_id(x, 1'b1, 1'b1); tick();
        snap = x;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(rand_rec(), 1'($urandom), 1'($urandom));
            flush = (i == 1); #1;
            n_tot++; if (stall !== 1'b1) $display("FAIL hold_stall[%0d] got %b want 1", i, stall); else n_pass++;
            tick();
            n_tot++; if (obs() !== snap) $display("FAIL hold_frozen[%0d] got %h want %h", i, obs(), snap); else n_pass++;
        end
        hold = 1'b0; flush = 1'b0;
        y = mk(1'b1, 1'b0, 5'b00101, 5'd13, 5'd3, 5'd4, 32'h44);
        set_id(y, 1'b1, 1'b1); tick();
        n_tot++; if (obs() !== y) $display("FAIL hold_resume got %h want %h", obs(), y); else n_pass++;
        n_tot++; if (bubble_cnt !== 16'(exp_bub)) $display("FAIL hold_cnt got %0d want %0d", bubble_cnt, exp_bub); else n_pass++;
    endtask

    task automatic test_saturation();
        int sat;
        for (int k = 0; k < 4; k++) begin
            set_id(mk(1'b1, 1'b1, 5'b00001, 5'd10, 5'd1, 5'd0, 32'h50), 1'b1, 1'b0); tick();
            set_id(mk(1'b1, 1'b0, 5'b00011, 5'd11, 5'd10, 5'd0, 32'h54), 1'b1, 1'b0); #1;
            n_tot++; if (stall !== 1'b1) $display("FAIL sat_stall[%0d] got %b want 1", k, stall); else n_pass++;
            tick(); exp_bub++;
            sat = (exp_bub > 3) ? 3 : exp_bub;
            n_tot++; if (bubble_cnt2 !== 2'(sat)) $display("FAIL sat_cnt2[%0d] got %0d want %0d", k, bubble_cnt2, sat); else n_pass++;
            n_tot++; if (bubble_cnt !== 16'(exp_bub)) $display("FAIL sat_cnt16[%0d] got %0d want %0d", k, bubble_cnt, exp_bub); else n_pass++;
            tick();
        end
    endtask

    task automatic test_reset_mid_stall();
        set_id(mk(1'b1, 1'b1, 5'b00001, 5'd11, 5'd1, 5'd0, 32'h60), 1'b1, 1'b0); tick();
        set_id(mk(1'b1, 1'b0, 5'b00011, 5'd12, 5'd2, 5'd11, 32'h64), 1'b1, 1'b1); #1;
        n_tot++; if (stall !== 1'b1) $display("FAIL mid_pre_stall got %b want 1", stall); else n_pass++;
        rstn = 1'b0; #1;
        n_tot++; if (stall !== 1'b0) $display("FAIL mid_stall got %b want 0", stall); else n_pass++;
        n_tot++; if (obs() !== '0) $display("FAIL mid_ex got %h want 0", obs()); else n_pass++;
        n_tot++; if (bubble_cnt !== 16'd0) $display("FAIL mid_cnt got %0d want 0", bubble_cnt); else n_pass++;
        exp_bub = 0;
        @(negedge clk); rstn = 1'b1;
    endtask

    task automatic test_random();
        rec_t r;
        logic exp_stall;
        rstn = 1'b0; hold = 1'b0; flush = 1'b0; #1;
        m = '0; m_cnt = 0; m_cnt2 = 0;
        @(negedge clk); rstn = 1'b1;
        for (int i = 0; i < 400; i++) begin
            r = rand_rec();
            r.Memread = ($urandom % 3) != 0;
            r.rd = 5'($urandom % 4); r.rs1 = 5'($urandom % 4); r.rs2 = 5'($urandom % 4);
            r.valid = ($urandom % 8) != 0;
            set_id(r, 1'($urandom), 1'($urandom));
            hold = ($urandom % 8) == 0;
            flush = ($urandom % 8) == 0;
            #1;
            exp_stall = hold || (m_load_use() && !flush);
            n_tot++; if (stall !== exp_stall) $display("FAIL rand_stall[%0d] got %b want %b", i, stall, exp_stall); else n_pass++;
            @(posedge clk);
            model_edge();
            #1;
            n_tot++; if (obs() !== m) $display("FAIL rand_ex[%0d] got %h want %h", i, obs(), m); else n_pass++;
            n_tot++; if (bubble_cnt !== 16'(m_cnt)) $display("FAIL rand_cnt[%0d] got %0d want %0d", i, bubble_cnt, m_cnt); else n_pass++;
            n_tot++; if (bubble_cnt2 !== 2'(m_cnt2)) $display("FAIL rand_cnt2[%0d] got %0d want %0d", i, bubble_cnt2, m_cnt2); else n_pass++;
            @(negedge clk);
        end
        hold = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_false_hazard();
        test_flush_hazard();
        test_hold();
        test_saturation();
        test_reset_mid_stall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between the instruction decoder/register-file read (ID) and the execute stage (EX).
- Latches the decoder's control bundle, the operands, the immediate, the PC and the register indices on every cycle.
- Performs load-use hazard detection: it inserts a bubble and stalls PC and IF/ID when needed.
- Applies flush requests from branch, jump or interrupt redirect, and keeps a saturating counter of inserted bubbles for performance debug.

Parameters:
XLEN, 32, datapath width of PC, operands and immediate
CNT_W, 16, width of the bubble counter

Ports:
clk  input  1  rising-edge clock
rstn  input  1  asynchronous active-low reset
id_RegWrite  input  1  decoder register-write enable
id_MemWrite  input  1  decoder store enable
id_Memread  input  1  decoder load enable
id_EXTOp  input  6  immediate-type one-hot
id_ALUOp  input  5  ALU operation
id_NPCOp  input  3  next-PC select
id_ALUSrc  input  1  ALU B from immediate
id_WDSel  input  3  writeback select
id_dm_ctrl  input  3  load/store width
id_pc  input  XLEN  PC of ID instruction
id_rs1_data  input  XLEN  rs1 read value
id_rs2_data  input  XLEN  rs2 read value
id_imm  input  XLEN  extended immediate
id_rs1  input  5  rs1 index
id_rs2  input  5  rs2 index
id_rd  input  5  rd index
id_uses_rs1  input  1  ID instruction reads rs1
id_uses_rs2  input  1  ID instruction reads rs2
id_valid  input  1  IF/ID holds a real instruction
flush  input  1  redirect from EX/interrupt; kill ID instruction
hold  input  1  downstream stall (memory busy); freeze EX register
ex_* (all id_* above except uses/valid)  output  same widths  registered copies
ex_valid  output  1  EX holds a real instruction
stall  output  1  freeze PC and IF/ID this cycle
bubble_cnt  output  CNT_W  bubbles inserted since reset

Behaviour:
- Reset (rstn=0, asynchronous): every ex_* output is 0, ex_valid=0 and bubble_cnt=0. stall is 0 during reset. EX contents after reset equal a bubble: all control fields 0, i.e. no register write, no memory access, NPCOp=000.
- hazard (combinational) = ex_valid & ex_Memread & (ex_rd!=0) & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- stall (combinational) = hold | (hazard & ~flush).
- Per-edge update, first matching rule wins:
  1. hold=1: EX register keeps its value (every ex_* field and ex_valid). bubble_cnt is unchanged. flush is ignored, because the redirecting instruction is frozen and will reassert it.
  2. flush=1: EX loads a bubble: control fields 0, ex_valid=0, data fields don't-care (the implementation zeroes them). bubble_cnt is unchanged (a flush is not a hazard bubble).
  3. hazard=1: EX loads a bubble. bubble_cnt increments by 1 and saturates at all-ones.
  4. Otherwise EX loads every id_* field, and ex_valid=id_valid. If id_valid=0, the control fields load as 0.
- Latency: 1 cycle from ID to EX.
- A load-use pair costs exactly one bubble. After the bubble, ex_Memread=0, so hazard deasserts and the consumer advances on the next edge.
- Index x0: ex_rd=0 never raises hazard.
- A store's rs2 after a load is treated as a use (bench drives id_uses_rs2=1); no special forwarding case.
- Reset mid-stall: all state clears at once, stall drops to 0 and the counter restarts at 0.
- Simultaneous hazard and flush: flush wins and stall=0, since IF/ID is being replaced anyway.

Test Plan:
- Reset and plain flow: assert rstn=0 with nonzero inputs, then drive add (id_RegWrite=1, id_ALUOp=5'b00011, id_rd=5, id_pc=0x10) -> during reset all ex_* are 0. On the first edge after release, ex_RegWrite=1, ex_ALUOp=00011, ex_rd=5, ex_pc=0x10, ex_valid=1, stall=0.
- Load-use: lw x6 in EX (ex_Memread=1, ex_rd=6), ID add with id_rs1=6, id_uses_rs1=1 -> stall=1. Next edge: ex_valid=0, control zero, bubble_cnt=1. Following cycle: stall=0, and the add enters EX on the next edge.
- No false hazard: load with ex_rd=0 and id_rs1=0; and load ex_rd=7 with id_rs2=7 but id_uses_rs2=0 -> stall=0 and no bubble in both cases.
- Flush with hazard: load-use condition plus flush=1 -> stall=0, EX gets a bubble, bubble_cnt unchanged.
- Hold: hold=1 for 3 cycles with changing id_* -> stall=1 throughout and ex_* frozen. A flush pulse during hold is ignored. After hold drops, normal capture resumes.
- Counter saturation: preload to 0xFFFE via repeated hazards (or CNT_W=2 build) -> increments to 0xFFFF (3 for CNT_W=2) and stays there on further hazards.
